wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges pipeline register writes with results from a multi-cycle
// mul/div unit, buffering up to two muldiv results and stalling the pipeline once one ages out.
module wb_port_arbiter #(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_reg_write,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_md_valid,
  input  logic [4:0]  i_md_rd,
  input  logic [31:0] i_md_data,
  output logic        o_md_ready,
  output logic        o_wb_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_data
);

  localparam int unsigned AgeW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
  localparam logic [AgeW-1:0] AgeMax = AgeW'(AGE_LIMIT);

  typedef enum logic [1:0] {StIdle, StPend, StForce} state_e;

  state_e          state_q, state_d;
  logic [1:0]      count_q, count_d;
  logic [AgeW-1:0] age_q, age_d;
  logic            rd_ptr_q, wr_ptr_q;
  logic [4:0]      fifo_rd_q   [2];
  logic [31:0]     fifo_data_q [2];

  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_data_q, rf_data_d;

  logic md_ready, enq, pop, wb_busy, fifo_nonempty, grant_wb;

  always_comb begin
    md_ready      = (count_q < 2'd2);
    enq           = i_md_valid && md_ready && (i_md_rd != 5'd0);
    wb_busy       = i_wb_reg_write && (i_wb_rd != 5'd0);
    fifo_nonempty = (count_q != 2'd0);

    // A result enqueued this cycle is not visible to the grant until count_q reflects it.
    pop      = fifo_nonempty && ((state_q == StForce) || !wb_busy);
    grant_wb = (state_q != StForce) && wb_busy;

    count_d = count_q + {1'b0, enq} - {1'b0, pop};

    if (!fifo_nonempty || pop) begin
      age_d = '0;
    end else if (age_q < AgeMax) begin
      age_d = age_q + 1'b1;
    end else begin
      age_d = age_q;
    end

    if (count_d == 2'd0) begin
      state_d = StIdle;
    end else if (age_d == AgeMax) begin
      state_d = StForce;
    end else begin
      state_d = StPend;
    end

    rf_we_d   = 1'b0;
    rf_rd_d   = '0;
    rf_data_d = '0;
    if (pop) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = fifo_rd_q[rd_ptr_q];
      rf_data_d = fifo_data_q[rd_ptr_q];
    end else if (grant_wb) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = i_wb_rd;
      rf_data_d = i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      age_q     <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      age_q     <= age_d;
      rd_ptr_q  <= rd_ptr_q ^ pop;
      wr_ptr_q  <= wr_ptr_q ^ enq;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && enq) begin
      fifo_rd_q[wr_ptr_q]   <= i_md_rd;
      fifo_data_q[wr_ptr_q] <= i_md_data;
    end
  end

  assign o_md_ready = md_ready;
  assign o_wb_stall = (state_q == StForce);
  assign o_rf_we    = rf_we_q;
  assign o_rf_rd    = rf_rd_q;
  assign o_rf_data  = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios queue the expected register-file
// writes in order; a negedge monitor pops and compares every write the DUT makes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [36:0] exp_q [$];

  wb_port_arbiter #(.AGE_LIMIT(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wb_reg_write (wb_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_data      (wb_data),
    .i_md_valid     (md_valid),
    .i_md_rd        (md_rd),
    .i_md_data      (md_data),
    .o_md_ready     (md_ready),
    .o_wb_stall     (wb_stall),
    .o_rf_we        (rf_we),
    .o_rf_rd        (rf_rd),
    .o_rf_data      (rf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  task automatic idle_inputs();
    wb_reg_write = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    md_valid     = 1'b0;
    md_rd        = '0;
    md_data      = '0;
  endtask

  // Monitor: every write must match the head of the expected queue; idle cycles must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rf_unexpected: got rd=%0d data=%h, expected no write", rf_rd, rf_data);
        end else begin
          check("rf_write", 64'({rf_rd, rf_data}), 64'(exp_q.pop_front()));
        end
      end else begin
        check("rf_idle_zero", 64'({rf_we, rf_rd, rf_data}), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  initial begin
    int k;
    int m;
    bit stall_now;
    bit rdy_now;

    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    check("rst_ready", 64'(md_ready), 64'd1);
    check("rst_stall", 64'(wb_stall), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single muldiv result into an idle pipeline: lands two edges after acceptance.
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h0000_00AA;
    check("s1_ready", 64'(md_ready), 64'd1);
    push_exp(5'd5, 32'h0000_00AA);
    tick();
    idle_inputs();
    check("s1_not_yet", 64'(rf_we), 64'd0);
    check("s1_stall_a", 64'(wb_stall), 64'd0);
    tick();
    check("s1_latency", 64'({rf_we, rf_rd, rf_data}), 64'({1'b1, 5'd5, 32'h0000_00AA}));
    check("s1_stall_b", 64'(wb_stall), 64'd0);
    repeat (3) tick();

    // Busy pipeline starves one result until it ages out and forces a one-cycle stall.
    for (int i = 0; i < 5; i++) push_exp(5'd3, 32'h100 + 32'(i));
    push_exp(5'd7, 32'h77);
    push_exp(5'd3, 32'h105);
    push_exp(5'd3, 32'h106);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      check("s2_stall", 64'(wb_stall), 64'(c == 5));
      stall_now    = wb_stall;
      wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h100 + 32'(k);
      md_valid     = (c == 0); md_rd = 5'd7; md_data = 32'h77;
      tick();
      if (!stall_now) k++;
    end
    idle_inputs();
    repeat (3) tick();

    // Three back-to-back results against a continuously busy pipeline: FIFO fills, third waits.
    for (int i = 0; i < 5; i++) push_exp(5'd3, 32'h200 + 32'(i));
    push_exp(5'd10, 32'h11);
    for (int i = 5; i < 9; i++) push_exp(5'd3, 32'h200 + 32'(i));
    push_exp(5'd11, 32'h22);
    for (int i = 9; i < 13; i++) push_exp(5'd3, 32'h200 + 32'(i));
    push_exp(5'd12, 32'h33);
    push_exp(5'd3, 32'h20D);
    push_exp(5'd3, 32'h20E);
    k = 0;
    m = 0;
    for (int c = 0; c < 18; c++) begin
      check("s3_stall", 64'(wb_stall), 64'(c == 5 || c == 10 || c == 15));
      check("s3_ready", 64'(md_ready), 64'(c < 2 || c == 6 || c >= 11));
      stall_now    = wb_stall;
      rdy_now      = md_ready;
      wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h200 + 32'(k);
      md_valid     = (m < 3); md_rd = 5'(10 + m); md_data = 32'h11 * 32'(m + 1);
      tick();
      if (!stall_now) k++;
      if (m < 3 && rdy_now) m++;
    end
    check("s3_all_accepted", 64'(m), 64'd3);
    idle_inputs();
    repeat (3) tick();

    // Writes to x0 from both sources: handshake completes, nothing reaches the register file.
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    md_valid     = 1'b1; md_rd = 5'd0; md_data = 32'hDEAD;
    check("s4_ready", 64'(md_ready), 64'd1);
    tick();
    idle_inputs();
    check("s4_we_a", 64'(rf_we), 64'd0);
    tick();
    check("s4_we_b", 64'(rf_we), 64'd0);
    check("s4_stall", 64'(wb_stall), 64'd0);
    repeat (2) tick();

    // Two entries buffered and in force, then reset: buffered results must be dropped.
    for (int c = 0; c < 5; c++) begin
      push_exp(5'd3, 32'h300 + 32'(c));
      wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h300 + 32'(c);
      md_valid     = (c < 2); md_rd = 5'(20 + c); md_data = 32'h500 + 32'(c);
      tick();
    end
    check("s5_force", 64'(wb_stall), 64'd1);
    check("s5_full", 64'(md_ready), 64'd0);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rf_we", 64'(rf_we), 64'd0);
    check("s5_stall", 64'(wb_stall), 64'd0);
    check("s5_ready", 64'(md_ready), 64'd1);
    repeat (8) tick();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
